riscv_muldiv: RTL
=================

// Module: riscv_muldiv
// PURPOSE
//  Multi-cycle RV32M execution unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Sits in EX beside the single-cycle ALU; the pipeline stalls on in_ready=0.
//  Widths are parametrised. Divide is iterative restoring, one quotient bit per cycle.
// PARAMETERS
//  WORD_LENGTH  32  operand/result width in bits; must be even and >=8
// PORTS
//  clk        in   1            single clock; all state updates on rising edge
//  rst        in   1            synchronous, active-high reset
//  md_fun     in   MD_FUN       operation select (package enum)
//  data1      in   WORD_LENGTH  rs1 operand / dividend
//  data2      in   WORD_LENGTH  rs2 operand / divisor
//  in_valid   in   1            request strobe
//  in_ready   out  1            unit can accept (state IDLE)
//  flush      in   1            abort in-flight op (branch mispredict / trap)
//  out_valid  out  1            md_out holds a result
//  out_ready  in   1            consumer takes the result
//  md_out     out  WORD_LENGTH  result
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, in_ready=1, out_valid=0, md_out=0, counter=0.
//  Accept when in_valid&&in_ready: latch md_fun, data1, data2; leave IDLE.
//  FSM: IDLE -> BUSY (normal op) | DONE (special case); BUSY -> DONE when cnt==WORD_LENGTH-1.
//   DONE -> IDLE when out_ready. flush in any state -> IDLE next edge with out_valid=0 (rst wins over flush).
//  in_ready=1 only in IDLE; out_valid=1 only in DONE; md_out is stable while out_valid=1 and out_ready=0.
//  Signed ops: operate on magnitudes; negate the quotient if signs differ; the remainder takes the dividend's sign.
//  Multiply (iterative): shift-add over 2*WORD_LENGTH product, WORD_LENGTH BUSY cycles.
//   MUL = product[W-1:0]; MULH/MULHSU/MULHU = product[2W-1:W] (s*s, s*u, u*u).
//  Divide: WORD_LENGTH BUSY cycles -> out_valid on the cycle W+1 after accept.
//  Special cases (no BUSY, out_valid 1 cycle after accept):
//   divisor==0: DIV/DIVU quotient = all ones; REM/REMU = data1.
//   signed overflow (data1=MIN, data2=-1): DIV = MIN, REM = 0.
//  Accept in the same cycle that DONE is consumed is not allowed: new request needs IDLE.
//  Undefined md_fun: treated as a special case, result 0, latency 1.
//  Counter width = $clog2(WORD_LENGTH); no wrap beyond WORD_LENGTH-1.
// CONFIGURATION
//  RISCV_MULDIV_FAST_MUL_EN defined: MUL* use one combinational 2W-bit multiplier.
//   Result is registered, so MUL* go IDLE -> DONE with latency 1. Divide is unchanged.
//  Undefined: MUL* take the iterative path above (latency WORD_LENGTH+1). No port/behaviour change otherwise.
// STRUCTURE
//  riscv_constants package: MD_FUN enum (MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
//   MD_DIV, MD_DIVU, MD_REM, MD_REMU) and the MD_STATE enum (MD_IDLE, MD_BUSY, MD_DONE).
//  One sub-module: riscv_muldiv_core -- the shared shift/add/subtract datapath
//   (acc, multiplicand/divisor, counter step), with FSM and sign fix-up in the top level.
// TESTING (W=32, iterative unless noted)
//  1 MUL 7*-3 -> out_valid at accept+33, md_out=0xFFFFFFEB; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
//  2 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2; latency 33.
//  3 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5 at accept+1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  4 out_ready held 0 for 5 cycles in DONE -> out_valid and md_out stable, in_ready=0; in_valid ignored.
//  5 flush at BUSY cycle 10 -> IDLE next edge, no out_valid; next DIVU 9/3 -> 3 correct.
//  6 rst mid-BUSY -> all outputs at reset values next edge; with RISCV_MULDIV_FAST_MUL_EN MULH latency=1.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// Shared RV32M encodings for the multiply/divide unit: operation select,
// FSM state encoding and operand-signedness helpers.
package riscv_constants;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_fun_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic src1_signed(input md_fun_t f);
        return f inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic src2_signed(input md_fun_t f);
        return f inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/riscv_muldiv_core.sv
// Shared unsigned datapath: shift-add multiply or restoring divide on a
// {hi, lo} accumulator pair, one bit per step, with the iteration counter.
module riscv_muldiv_core
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   step,
    input  logic                   div_mode,
    input  logic [WORD_LENGTH-1:0] op_a,
    input  logic [WORD_LENGTH-1:0] op_b,
    output logic [WORD_LENGTH-1:0] hi_next,
    output logic [WORD_LENGTH-1:0] lo_next,
    output logic                   last
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  opnd;
    logic          is_div;
    logic [CW-1:0] cnt;
    logic [W:0]    sum;
    logic [W:0]    trial;

    // Multiply: lo holds the multiplier and drains out as product bits shift in.
    // Divide: lo holds the dividend and fills with quotient bits; hi is the remainder.
    always_comb begin
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        trial = {hi, lo[W-1]} - {1'b0, opnd};
        if (is_div) begin
            hi_next = trial[W] ? {hi[W-2:0], lo[W-1]} : trial[W-1:0];
            lo_next = {lo[W-2:0], ~trial[W]};
        end else begin
            hi_next = sum[W:1];
            lo_next = {sum[0], lo[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            hi     <= '0;
            lo     <= op_a;
            opnd   <= op_b;
            is_div <= div_mode;
        end else if (step) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/riscv_muldiv.sv
// Multi-cycle RV32M execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Define RISCV_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module riscv_muldiv
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  md_fun_t                md_fun,
    input  logic [WORD_LENGTH-1:0] data1,
    input  logic [WORD_LENGTH-1:0] data2,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] md_out
);

    localparam int W = WORD_LENGTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    md_state_t      state;
    md_state_t      state_next;
    md_fun_t        fun_q;
    logic           neg_q;
    logic           rem_neg_q;
    logic           accept;
    logic           a_neg;
    logic           b_neg;
    logic           div_zero;
    logic           div_ovf;
    logic           special;
    logic           core_start;
    logic           core_step;
    logic           core_last;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W-1:0]   special_res;
    logic [W-1:0]   core_hi;
    logic [W-1:0]   core_lo;
    logic [W-1:0]   iter_res;
    logic [2*W-1:0] prod_mag;
    logic [2*W-1:0] prod_signed;
`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_prod;
`endif

    assign accept = in_valid && (state == MD_IDLE) && !flush;

    // Signed operations run on magnitudes; the sign is restored on the way out.
    assign a_neg    = src1_signed(md_fun) && data1[W-1];
    assign b_neg    = src2_signed(md_fun) && data2[W-1];
    assign a_mag    = a_neg ? -data1 : data1;
    assign b_mag    = b_neg ? -data2 : data2;
    assign div_zero = (data2 == '0);
    assign div_ovf  = (data1 == MIN_VAL) && (data2 == '1);

`ifdef RISCV_MULDIV_FAST_MUL_EN
    assign fast_prod = {{W{a_neg}}, data1} * {{W{b_neg}}, data2};
`endif

    // Requests that finish in one cycle and never touch the iterative datapath.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        case (md_fun)
            MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU: begin
`ifdef RISCV_MULDIV_FAST_MUL_EN
                special     = 1'b1;
                special_res = (md_fun == MD_MUL) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`endif
            end
            MD_DIV: begin
                if (div_zero) begin
                    special     = 1'b1;
                    special_res = '1;
                end else if (div_ovf) begin
                    special     = 1'b1;
                    special_res = MIN_VAL;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    special     = 1'b1;
                    special_res = '1;
                end
            end
            MD_REM: begin
                if (div_zero) begin
                    special     = 1'b1;
                    special_res = data1;
                end else if (div_ovf) begin
                    special     = 1'b1;
                    special_res = '0;
                end
            end
            MD_REMU: begin
                if (div_zero) begin
                    special     = 1'b1;
                    special_res = data1;
                end
            end
            default: begin
                special     = 1'b1;
                special_res = '0;
            end
        endcase
    end

    assign core_start = accept && !special;
    assign core_step  = (state == MD_BUSY) && !flush;

    riscv_muldiv_core #(
        .WORD_LENGTH(W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .step     (core_step),
        .div_mode (md_fun[2]),
        .op_a     (a_mag),
        .op_b     (b_mag),
        .hi_next  (core_hi),
        .lo_next  (core_lo),
        .last     (core_last)
    );

    // Result selection taps the final step's combinational values so the
    // answer lands in md_out on the same edge that enters DONE.
    always_comb begin
        prod_mag    = {core_hi, core_lo};
        prod_signed = neg_q ? -prod_mag : prod_mag;
        iter_res    = '0;
        case (fun_q)
            MD_MUL:                       iter_res = prod_signed[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: iter_res = prod_signed[2*W-1:W];
            MD_DIV, MD_DIVU:              iter_res = neg_q ? -core_lo : core_lo;
            default:                      iter_res = rem_neg_q ? -core_hi : core_hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            MD_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = special ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (core_last) begin
                    state_next = MD_DONE;
                end
            end
            MD_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = MD_IDLE;
                end
            end
            default: state_next = MD_IDLE;
        endcase
        if (flush) begin
            state_next = MD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fun_q     <= md_fun;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_out <= '0;
        end else if (accept && special) begin
            md_out <= special_res;
        end else if (core_step && core_last) begin
            md_out <= iter_res;
        end
    end

endmodule
